mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum RAM wait cycles before an access is aborted.
REQ-002 Parameter BADWORD, default 32'hBAD1BAD1: load value returned on a timed-out read.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 iREN  in  1  instruction fetch request from the datapath.
REQ-006 iaddr  in  32  fetch address.
REQ-007 dREN  in  1  data read request.
REQ-008 dWEN  in  1  data write request.
REQ-009 datomic  in  1  qualifies dREN as LL and dWEN as SC.
REQ-010 daddr  in  32  data address.
REQ-011 dstore  in  32  write data.
REQ-012 ihit  out  1  one-cycle pulse: fetch complete.
REQ-013 iload  out  32  fetched word; held until the next ihit.
REQ-014 dhit  out  1  one-cycle pulse: data access complete.
REQ-015 dload  out  32  read word, or SC result (1 success, 0 fail); held until the next dhit.
REQ-016 ramREN  out  1  RAM read strobe.
REQ-017 ramWEN  out  1  RAM write strobe.
REQ-018 ramaddr  out  32  RAM word address.
REQ-019 ramstore  out  32  RAM write data.
REQ-020 ramload  in  32  RAM read data, valid with ram_ready.
REQ-021 ram_ready  in  1  RAM completes the current access this cycle.
REQ-022 timeout_err  out  1  one-cycle pulse coincident with a hit that ended by timeout.

Function
REQ-023 The FSM SHALL have states IDLE, DATA, INSTR, SCFAIL.
REQ-024 In IDLE, if dREN or dWEN is high, the FSM SHALL go to DATA; otherwise, if iREN is high, to INSTR; otherwise it stays in IDLE. Data requests have priority.
REQ-025 Request address, store data, type and datomic SHALL be latched on leaving IDLE; later input changes SHALL NOT affect the access in flight.
REQ-026 If dREN and dWEN are both high, the access SHALL be a write.
REQ-027 In DATA and INSTR, the strobes SHALL be driven combinationally from state: ramREN=1 for reads and fetches, ramWEN=1 for writes, never both.
REQ-028 ramaddr SHALL be the latched address with bits [1:0] forced to 00.
REQ-029 ramstore SHALL be the latched dstore during writes, otherwise 0.
REQ-030 Outside DATA and INSTR, ramREN=ramWEN=0 and ramaddr=0.
REQ-031 When ram_ready=1 in DATA or INSTR, the block SHALL do all of the following on the next clock edge:
- pulse the matching hit;
- register ramload into the matching load for reads (dload=1 for a successful SC; dload unchanged for a plain SW);
- return to IDLE.
REQ-032 Latency SHALL be one cycle from request to strobe, and one cycle from ram_ready to hit. With ram_ready on the first strobe cycle, hit occurs 2 cycles after the request.
REQ-033 IDLE SHALL last at least one cycle between accesses, so a pending fetch is served after every data access.
REQ-034 A wait counter SHALL clear on entry to DATA/INSTR and increment each non-ready cycle.
REQ-035 When the wait counter reaches TIMEOUT, the access SHALL complete as if ram_ready were high, with the load = BADWORD for reads and timeout_err pulsed with the hit.
REQ-036 LL (dREN & datomic) completion SHALL set link_valid=1 and link_addr=word address.
REQ-037 SC (dWEN & datomic) in IDLE with link_valid=1 and a link_addr match SHALL go to DATA and perform the write; otherwise it SHALL go to SCFAIL.
REQ-038 In SCFAIL there SHALL be no RAM strobe; the next edge SHALL set dload=0, pulse dhit and return to IDLE.
REQ-039 Every SC, pass or fail, SHALL clear link_valid on completion.
REQ-040 A non-atomic write completing to link_addr SHALL clear link_valid.
REQ-041 If an LL and a clearing write complete in the same cycle, the LL SHALL win (link set).
REQ-042 A request deasserted mid-access SHALL NOT abort it; the hit still pulses.

Reset
REQ-043 RST=1 at a clock edge SHALL force the following, including mid-access:
- state IDLE;
- ihit=dhit=timeout_err=0;
- iload=dload=0;
- link_valid=0, link_addr=0;
- wait counter 0.
REQ-044 During the reset cycle, ramREN=ramWEN=0, and the in-flight access SHALL be dropped with no hit.

Verification
REQ-045 Fetch: iREN=1, iaddr=32'h40, and RAM returns 32'h2408000A after 3 waits. Required: ramREN high 4 cycles; ihit once; iload=32'h2408000A; ramaddr=32'h40.
REQ-046 Priority: iREN and dREN both high, daddr=32'h103 (expected ramaddr 32'h100). Required: data access first; dhit; one IDLE cycle; then the fetch and ihit.
REQ-047 LL/SC pass: LL 32'h200, then SC 32'h200 with dstore=32'h7. Required: ramWEN=1, ramstore=7; dload=1. A second SC to 32'h200 gives SCFAIL, no ramWEN, dload=0.
REQ-048 Link break: LL 32'h200, SW 32'h200, then SC 32'h200. Required: SC fails with dload=0 and no RAM write.
REQ-049 Timeout: dREN with ram_ready held 0. Required: dhit after TIMEOUT+1 strobe cycles; dload=32'hBAD1BAD1; timeout_err pulses with the hit.
REQ-050 Reset mid-access: RST=1 on the 2nd wait cycle of a write. Required: strobes 0 the same cycle; no dhit; state IDLE; link_valid=0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter: single-port RAM arbiter for fetch and data with LL/SC and timeout
// Revision: 1.0
// ============================================================================
module mem_arbiter #(
  parameter int          TIMEOUT = 15,
  parameter logic [31:0] BADWORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        datomic,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        timeout_err
);

  localparam int            CW         = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    INSTR  = 2'd2,
    SCFAIL = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [31:0]   addr_q;
  logic [31:0]   store_q;
  logic          is_write;
  logic          is_atomic;
  logic [CW-1:0] wait_cnt;
  logic          link_valid;
  logic [31:0]   link_addr;

  logic          data_req;
  logic          sc_req;
  logic          sc_ok;
  logic          timed_out;
  logic          done;
  logic [31:0]   word_addr;
  logic          unused_low_bits;

  assign word_addr       = {addr_q[31:2], 2'b00};
  assign unused_low_bits = ^{addr_q[1:0], link_addr[1:0]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    data_req   = dREN | dWEN;
    sc_req     = dWEN & datomic;
    sc_ok      = link_valid && (link_addr[31:2] == daddr[31:2]);
    timed_out  = !ram_ready && (wait_cnt == WAIT_LIMIT);
    done       = ram_ready || timed_out;
    case (state)
      IDLE: begin
        if (data_req) begin
          state_next = (sc_req && !sc_ok) ? SCFAIL : DATA;
        end else if (iREN) begin
          state_next = INSTR;
        end
      end
      DATA: begin
        // Strobes drop in the reset cycle so the aborted access never touches RAM.
        ramaddr = word_addr;
        ramREN  = !is_write && !RST;
        ramWEN  = is_write && !RST;
        if (is_write) begin
          ramstore = store_q;
        end
        if (done) begin
          state_next = IDLE;
        end
      end
      INSTR: begin
        ramaddr = word_addr;
        ramREN  = !RST;
        if (done) begin
          state_next = IDLE;
        end
      end
      SCFAIL: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ihit        <= 1'b0;
      dhit        <= 1'b0;
      timeout_err <= 1'b0;
      iload       <= '0;
      dload       <= '0;
      link_valid  <= 1'b0;
      link_addr   <= '0;
      wait_cnt    <= '0;
      addr_q      <= '0;
      store_q     <= '0;
      is_write    <= 1'b0;
      is_atomic   <= 1'b0;
    end else begin
      ihit        <= 1'b0;
      dhit        <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (data_req) begin
            addr_q    <= daddr;
            store_q   <= dstore;
            is_write  <= dWEN;
            is_atomic <= datomic;
          end else if (iREN) begin
            addr_q    <= iaddr;
            store_q   <= '0;
            is_write  <= 1'b0;
            is_atomic <= 1'b0;
          end
        end
        DATA: begin
          if (done) begin
            dhit        <= 1'b1;
            timeout_err <= timed_out;
            if (!is_write) begin
              dload <= timed_out ? BADWORD : ramload;
              if (is_atomic) begin
                link_valid <= 1'b1;
                link_addr  <= word_addr;
              end
            end else if (is_atomic) begin
              dload      <= 32'd1;
              link_valid <= 1'b0;
            end else if (link_addr[31:2] == addr_q[31:2]) begin
              link_valid <= 1'b0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        INSTR: begin
          if (done) begin
            ihit        <= 1'b1;
            timeout_err <= timed_out;
            iload       <= timed_out ? BADWORD : ramload;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SCFAIL: begin
          dhit       <= 1'b1;
          dload      <= '0;
          link_valid <= 1'b0;
        end
        default: begin
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: directed scenarios plus random traffic, compared every cycle
// against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int          TIMEOUT = 15;
  localparam logic [31:0] BADWORD = 32'hBAD1BAD1;
  localparam int K_NONE = 0, K_FETCH = 1, K_READ = 2, K_WRITE = 3, K_SCFAIL = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, datomic = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic        ihit, dhit, ramREN, ramWEN, timeout_err, ram_ready;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;

  int          rdy_mode = 0;
  int          wait_n = 0;
  int          run = 0;
  logic        rdy_rand = 1'b0;
  logic        fixed_en = 1'b0;
  logic [31:0] fixed_val = '0;
  logic        chk_en = 1'b0;

  int n_chk = 0, n_fail = 0, cyc_n = 0;
  int cnt_ren = 0, cnt_wen = 0, cnt_ihit = 0, cnt_dhit = 0, cnt_terr = 0, cnt_terr_hit = 0;
  int t_ihit = -1, t_dhit = -1;
  logic [31:0] first_addr = '0, last_store = '0;
  bit got_first = 0;

  mem_arbiter #(.TIMEOUT(TIMEOUT), .BADWORD(BADWORD)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .datomic(datomic), .daddr(daddr), .dstore(dstore), .ihit(ihit), .iload(iload),
    .dhit(dhit), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ram_word(input logic [31:0] a, input logic fe, input logic [31:0] fv);
    if (fe) return fv;
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  assign ramload   = ram_word(ramaddr, fixed_en, fixed_val);
  assign ram_ready = (rdy_mode == 0) ? rdy_rand : (rdy_mode == 1) ? (run == wait_n) : 1'b0;

  // Strobe cycles elapsed in the current access, for the "ready after N waits" RAM.
  always @(posedge CLK) run <= (ramREN || ramWEN) ? run + 1 : 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Reference model: one outstanding transaction, completed by ready or by the
  // (TIMEOUT+1)th strobe cycle; link register updated on completion.
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    bit          atomic;
    int          strobes;
  } txn_t;

  txn_t        cur;
  bit          lv = 0;
  logic [31:0] la = '0;
  logic        e_ihit = 0, e_dhit = 0, e_terr = 0;
  logic [31:0] e_iload = '0, e_dload = '0;

  always @(posedge CLK) begin
    logic [31:0] wa;
    bit          tmo;
    e_ihit = 0; e_dhit = 0; e_terr = 0;
    if (RST) begin
      cur.kind = K_NONE; cur.strobes = 0;
      e_iload = '0; e_dload = '0; lv = 0; la = '0;
    end else begin
      case (cur.kind)
        K_NONE: begin
          if (dREN || dWEN) begin
            cur.addr = daddr; cur.data = dstore; cur.atomic = datomic; cur.strobes = 0;
            if (dWEN && datomic && !(lv && la[31:2] == daddr[31:2])) cur.kind = K_SCFAIL;
            else cur.kind = dWEN ? K_WRITE : K_READ;
          end else if (iREN) begin
            cur.kind = K_FETCH; cur.addr = iaddr; cur.data = '0; cur.atomic = 0; cur.strobes = 0;
          end
        end
        K_SCFAIL: begin
          e_dload = '0; e_dhit = 1; lv = 0; cur.kind = K_NONE;
        end
        default: begin
          cur.strobes++;
          if (ram_ready || cur.strobes == TIMEOUT + 1) begin
            tmo = !ram_ready;
            wa = {cur.addr[31:2], 2'b00};
            e_terr = tmo;
            if (cur.kind == K_FETCH) begin
              e_ihit = 1;
              e_iload = tmo ? BADWORD : ram_word(wa, fixed_en, fixed_val);
            end else begin
              e_dhit = 1;
              if (cur.kind == K_READ) begin
                e_dload = tmo ? BADWORD : ram_word(wa, fixed_en, fixed_val);
                if (cur.atomic) begin lv = 1; la = wa; end
              end else if (cur.atomic) begin
                e_dload = 32'd1; lv = 0;
              end else if (lv && la[31:2] == wa[31:2]) begin
                lv = 0;
              end
            end
            cur.kind = K_NONE;
          end
        end
      endcase
    end
  end

  always @(negedge CLK) begin
    bit acc;
    cyc_n++;
    acc = (cur.kind == K_FETCH) || (cur.kind == K_READ) || (cur.kind == K_WRITE);
    if (chk_en) begin
      chk("ihit", ihit, e_ihit);
      chk("dhit", dhit, e_dhit);
      chk("timeout_err", timeout_err, e_terr);
      chk("iload", iload, e_iload);
      chk("dload", dload, e_dload);
      chk("ramREN", ramREN, !RST && (cur.kind == K_FETCH || cur.kind == K_READ));
      chk("ramWEN", ramWEN, !RST && cur.kind == K_WRITE);
      chk("ramaddr", ramaddr, acc ? {cur.addr[31:2], 2'b00} : 32'h0);
      chk("ramstore", ramstore, (cur.kind == K_WRITE) ? cur.data : 32'h0);
    end
    if (ramREN) cnt_ren++;
    if (ramWEN) begin cnt_wen++; last_store = ramstore; end
    if ((ramREN || ramWEN) && !got_first) begin first_addr = ramaddr; got_first = 1; end
    if (ihit) begin cnt_ihit++; t_ihit = cyc_n; end
    if (dhit) begin cnt_dhit++; t_dhit = cyc_n; end
    if (timeout_err) cnt_terr++;
    if (timeout_err && dhit) cnt_terr_hit++;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    cnt_ren = 0; cnt_wen = 0; cnt_ihit = 0; cnt_dhit = 0; cnt_terr = 0; cnt_terr_hit = 0;
    t_ihit = -1; t_dhit = -1; got_first = 0;
  endtask

  task automatic data_op(input bit wr, input bit at, input logic [31:0] a,
                         input logic [31:0] d, input int settle);
    daddr = a; dstore = d; datomic = at; dWEN = wr; dREN = !wr;
    cyc();
    dREN = 0; dWEN = 0; datomic = 0;
    repeat (settle) cyc();
  endtask

  initial begin
    bit slow;
    slow = 0;
    RST = 1;
    repeat (3) cyc();
    chk_en = 1;
    chk("rst_ihit", ihit, 0);
    chk("rst_dhit", dhit, 0);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_ramREN", ramREN, 0);
    RST = 0;
    cyc();

    // Fetch with three wait cycles
    fixed_en = 1; fixed_val = 32'h2408000A; rdy_mode = 1; wait_n = 3;
    clr();
    iaddr = 32'h40; iREN = 1;
    cyc();
    iREN = 0;
    repeat (8) cyc();
    chk("fetch_ren_cycles", cnt_ren, 4);
    chk("fetch_ihit_count", cnt_ihit, 1);
    chk("fetch_iload", iload, 32'h2408000A);
    chk("fetch_ramaddr", first_addr, 32'h40);
    fixed_en = 0;

    // Data beats fetch; fetch follows after one IDLE cycle
    wait_n = 0;
    clr();
    iaddr = 32'h80; daddr = 32'h103; iREN = 1; dREN = 1;
    cyc();
    dREN = 0;
    cyc();
    cyc();
    iREN = 0;
    repeat (6) cyc();
    chk("prio_first_addr", first_addr, 32'h100);
    chk("prio_dhit_count", cnt_dhit, 1);
    chk("prio_ihit_count", cnt_ihit, 1);
    chk("prio_gap", t_ihit - t_dhit, 2);

    // LL then SC pass, then SC fail
    data_op(0, 1, 32'h200, 0, 4);
    clr();
    data_op(1, 1, 32'h200, 32'h7, 4);
    chk("sc_pass_wen", cnt_wen, 1);
    chk("sc_pass_store", last_store, 32'h7);
    chk("sc_pass_dload", dload, 1);
    clr();
    data_op(1, 1, 32'h200, 32'h7, 4);
    chk("sc_again_wen", cnt_wen, 0);
    chk("sc_again_dhit", cnt_dhit, 1);
    chk("sc_again_dload", dload, 0);

    // Plain store to the linked word breaks the link
    data_op(0, 1, 32'h200, 0, 4);
    data_op(1, 0, 32'h200, 32'h5, 4);
    clr();
    data_op(1, 1, 32'h200, 32'h9, 4);
    chk("link_break_wen", cnt_wen, 0);
    chk("link_break_dload", dload, 0);

    // Read timeout
    rdy_mode = 2;
    clr();
    data_op(0, 0, 32'h300, 0, TIMEOUT + 6);
    chk("tmo_ren_cycles", cnt_ren, TIMEOUT + 1);
    chk("tmo_dload", dload, BADWORD);
    chk("tmo_err_count", cnt_terr, 1);
    chk("tmo_err_with_hit", cnt_terr_hit, 1);

    // Reset during the second wait cycle of a write, with a live link
    rdy_mode = 1; wait_n = 0;
    data_op(0, 1, 32'h200, 0, 4);
    rdy_mode = 2;
    clr();
    daddr = 32'h10; dstore = 32'h9; dWEN = 1;
    cyc();
    dWEN = 0;
    cyc();
    RST = 1;
    #1;
    chk("rst_mid_wen", ramWEN, 0);
    cyc();
    RST = 0;
    rdy_mode = 1; wait_n = 0;
    chk("rst_mid_ramaddr", ramaddr, 0);
    repeat (5) cyc();
    chk("rst_mid_no_dhit", cnt_dhit, 0);
    clr();
    data_op(1, 1, 32'h200, 32'h3, 4);
    chk("rst_link_cleared_wen", cnt_wen, 0);
    chk("rst_link_cleared_dload", dload, 0);

    // Random traffic
    rdy_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) slow = ($urandom_range(0, 3) == 0);
      rdy_rand = slow ? 1'b0 : 1'($urandom_range(0, 1));
      iREN     = ($urandom_range(0, 2) != 0);
      iaddr    = $urandom;
      dREN     = ($urandom_range(0, 3) == 0);
      dWEN     = ($urandom_range(0, 4) == 0);
      datomic  = 1'($urandom_range(0, 1));
      daddr    = 32'h200 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
      dstore   = $urandom;
      RST      = ($urandom_range(0, 299) == 0);
      cyc();
    end
    RST = 0; iREN = 0; dREN = 0; dWEN = 0; datomic = 0;
    repeat (TIMEOUT + 5) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
